stopwatch_bcd_counter: RTL and testbench

//  Stopwatch timebase and BCD digit counter, M:SS.t format, range 0:00.0 to 9:59.9.

---
 rtl/stopwatch_bcd_counter.sv | 72 +++++++
 tb/tb_stopwatch_bcd_counter.sv | 106 ++++++++++
 2 files changed

// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter: M:SS.t stopwatch timebase and BCD digit chain, 0:00.0 to 9:59.9.
// Define LAP_HOLD_EN to let lap pulses freeze the displayed digits while counting goes on.
module stopwatch_bcd_counter #(
  parameter int TENTH_DIV = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] Minutes,
  output logic [3:0] Tens_Seconds,
  output logic [3:0] Ones_Seconds,
  output logic [3:0] Tenths_Seconds,
  output logic       running,
  output logic       rollover
);
  localparam int PW = $clog2(TENTH_DIV);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic [3:0] mi, ts, os, te, mi_n, ts_n, os_n, te_n;
  logic tick, c_te, c_os, c_ts, wrap;
  always_comb begin
    tick = state == RUN && presc == PW'(TENTH_DIV - 1);
    c_te = tick && te == 4'd9;
    c_os = c_te && os == 4'd9;
    c_ts = c_os && ts == 4'd5;
    wrap = c_ts && mi == 4'd9;
    state_next = clear ? IDLE : !start_stop ? state : state == RUN ? PAUSE : RUN;
    presc_next = (clear || state == IDLE || tick) ? '0 : state == RUN ? presc + PW'(1) : presc;
    te_n = (clear || c_te) ? 4'd0 : tick ? te + 4'd1 : te;
    os_n = (clear || c_os) ? 4'd0 : c_te ? os + 4'd1 : os;
    ts_n = (clear || c_ts) ? 4'd0 : c_os ? ts + 4'd1 : ts;
    mi_n = (clear || wrap) ? 4'd0 : c_ts ? mi + 4'd1 : mi;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      {mi, ts, os, te} <= '0;
      running  <= 1'b0;
      rollover <= 1'b0;
    end else begin
      state    <= state_next;
      presc    <= presc_next;
      {mi, ts, os, te} <= {mi_n, ts_n, os_n, te_n};
      running  <= state_next == RUN;
      rollover <= wrap && !clear;
    end
  end
`ifdef LAP_HOLD_EN
  logic hold, hold_next;
  logic [15:0] shown;
  // While held, shown keeps the value it had on the lap edge, i.e. the pre-edge live count.
  always_comb hold_next = clear ? 1'b0 : (lap && state != IDLE) ? !hold : hold;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold  <= 1'b0;
      shown <= '0;
    end else begin
      hold  <= hold_next;
      shown <= hold_next ? shown : {mi_n, ts_n, os_n, te_n};
    end
  end
  assign {Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds} = shown;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign {Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds} = {mi, ts, os, te};
`endif
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// tb_stopwatch_bcd_counter: random stimulus, tenths-count reference model, queued scoreboard.
module tb_stopwatch_bcd_counter;
  localparam int TD = 4;
  logic clk = 1'b0, reset = 1'b1, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [3:0] mi, ts, os, te;
  logic running, rollover;
  stopwatch_bcd_counter #(.TENTH_DIV(TD)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
    .Minutes(mi), .Tens_Seconds(ts), .Ones_Seconds(os), .Tenths_Seconds(te),
    .running(running), .rollover(rollover)
  );
  always #5 clk = ~clk;
  typedef struct {int disp; int run; int roll;} exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  int m_count = 0, m_phase = 0, m_state = 0, m_latched = 0, roll_exp = 0, roll_seen = 0;
  bit m_hold = 0, m_roll = 0;
  task automatic check(string name, int act, int req);
    compared++;
    if (act != req) begin
      mismatched++;
      if (mismatched <= 30) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask
  // Reference: stopwatch state as a plain count of tenths (0..5999) plus a cycle phase.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_count = 0; m_phase = 0; m_state = 0; m_hold = 0; m_latched = 0; m_roll = 0;
    end else begin
      if (clear) begin
        m_count = 0; m_phase = 0; m_state = 0; m_hold = 0; m_roll = 0;
      end else begin
        m_roll = 0;
`ifdef LAP_HOLD_EN
        if (lap && m_state != 0) begin
          if (m_hold) m_hold = 0;
          else begin m_hold = 1; m_latched = m_count; end
        end
`endif
        if (m_state == 1) begin
          m_phase++;
          if (m_phase == TD) begin
            m_phase = 0;
            m_count++;
            if (m_count == 6000) begin m_count = 0; m_roll = 1; roll_exp++; end
          end
        end
        if (start_stop) m_state = (m_state == 1) ? 2 : 1;
      end
      q.push_back('{m_hold ? m_latched : m_count, int'(m_state == 1), int'(m_roll)});
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (!reset && q.size() > 0) begin
      e = q.pop_front();
      check("minutes", int'(mi), e.disp / 600);
      check("tens_seconds", int'(ts), (e.disp % 600) / 100);
      check("ones_seconds", int'(os), (e.disp % 100) / 10);
      check("tenths_seconds", int'(te), e.disp % 10);
      check("running", int'(running), e.run);
      check("rollover", int'(rollover), e.roll);
      roll_seen += int'(rollover);
    end
  end
  task automatic random_phase(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start_stop = $urandom_range(15) == 0;
      clear      = $urandom_range(79) == 0;
      lap        = $urandom_range(31) == 0;
    end
    @(negedge clk);
    {start_stop, clear, lap} = '0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_digits", int'({mi, ts, os, te}), 0);
    check("reset_running", int'(running), 0);
    check("reset_rollover", int'(rollover), 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) start_stop = 1'b1;
    @(negedge clk) start_stop = 1'b0;
    repeat (24020) @(negedge clk);
    random_phase(4000);
    clear = 1'b1;
    @(negedge clk) begin clear = 1'b0; start_stop = 1'b1; end
    @(negedge clk) start_stop = 1'b0;
    repeat (30) @(negedge clk);
    check("pre_reset_tenths_nonzero", int'(te != 4'd0 || os != 4'd0), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_digits", int'({mi, ts, os, te}), 0);
    check("async_reset_running", int'(running), 0);
    check("async_reset_rollover", int'(rollover), 0);
    @(negedge clk) reset = 1'b0;
    random_phase(1500);
    repeat (3) @(negedge clk);
    check("rollover_pulses", roll_seen, roll_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
